usb_unstuff_deser: RTL and testbench
====================================

Name: usb_unstuff_deser

Overview:
- Receive-path stage directly downstream of nrzi_decode in the USB decode chain.
- Consumes decoded serial bits (data, valid, error). Hunts for the SYNC pattern, then removes stuffed bits and assembles LSB-first bytes.
- Emits framed bytes with start and end markers and error reporting to the packet parser.

Parameters:
- STUFF_RUN, 6, number of consecutive 1s after which the next received bit is a stuffed 0.
- MAX_BYTES, 64, maximum data bytes accepted per packet (SYNC excluded); range 1..1024.
- CNT_W, $clog2(MAX_BYTES+1), width of the byte counter (derived; not overridden).

Ports:
- i_clk  in  1  single clock.
- i_rst  in  1  reset; asynchronous, active-high.
- i_data  in  1  decoded bit from nrzi_decode.
- i_valid  in  1  i_data qualifier; one bit per asserted cycle.
- i_error  in  1  upstream decode error; sampled only when i_valid=1.
- i_eop  in  1  end-of-packet strobe (SE0 seen by line-state logic); independent of i_valid.
- o_byte  out  8  assembled byte; first received bit in bit 0.
- o_byte_valid  out  1  one-cycle pulse; o_byte is valid.
- o_sop  out  1  pulse coincident with the first o_byte_valid of a packet.
- o_eop  out  1  one-cycle pulse on a clean or misaligned packet end.
- o_byte_count  out  CNT_W  bytes emitted in the current or most recent packet.
- o_err  out  1  one-cycle error pulse.
- o_err_code  out  2  valid with o_err: 0=STUFF, 1=ALIGN, 2=UPSTREAM, 3=OVERFLOW.

Behaviour:
- Reset: all outputs 0; state=HUNT; shift register, bit counter and ones counter cleared.
- Outputs are registered. Each pulse appears the cycle after the input cycle that causes it.
- **HUNT state:**
  - Every valid bit shifts into an 8-bit history, newest bit into bit 7.
  - When the history equals 8'h80 (seven 0s, then a 1), go to DATA: ones_cnt=1, bit_cnt=0, byte_count=0, first_byte flag set.
  - i_error in HUNT clears the history. i_eop in HUNT is ignored.
- **DATA state, per valid bit:**
  - If i_error=1: o_err, code UPSTREAM; go to DROP.
  - Else if ones_cnt==STUFF_RUN:
    - Bit 0: discard it (stuffed bit); ones_cnt=0; bit_cnt unchanged.
    - Bit 1: o_err, code STUFF; go to DROP.
  - Else: ones_cnt = i_data ? ones_cnt+1 : 0; shift the bit into the byte register LSB-first; bit_cnt++.
  - On the 8th bit: pulse o_byte_valid with the byte; o_sop if first_byte (then clear the flag); byte_count++; bit_cnt wraps to 0.
  - If the byte would make byte_count exceed MAX_BYTES: no o_byte_valid; o_err, code OVERFLOW; go to DROP.
- **i_eop in DATA:**
  - bit_cnt==0: pulse o_eop; go to HUNT.
  - bit_cnt!=0: partial byte discarded; o_err code ALIGN and o_eop pulse in the same cycle; go to HUNT.
  - A pending stuffed bit (ones_cnt==STUFF_RUN) at EOP is not an error.
- **i_eop and i_valid in the same cycle:** i_eop wins; the bit is discarded.
- **DROP state:** all bits ignored. i_eop returns to HUNT without an o_eop pulse. At most one o_err per packet.
- **o_byte_count:** holds its value after EOP or error until the next SYNC clears it.
- o_byte holds its last value between pulses.
- Reset asserted mid-packet: immediate return to reset values. No pulses on the cycle of reset release.

Decomposition:
- usb_pkg holds:
  - state enum (HUNT, DATA, DROP)
  - err code enum
  - USB_SYNC constant 8'h80
  - default STUFF_RUN
- Natural sub-module: usb_sync_hunt. It contains the 8-bit history and comparator and outputs a one-cycle sync_found. The remaining FSM and datapath stay in usb_unstuff_deser.

Test Plan:
- **Clean packet:** SYNC, 0xA5 (bits 1,0,1,0,0,1,0,1), i_eop → one o_byte_valid with o_byte=0xA5 and o_sop=1; o_eop next; o_byte_count=1; no o_err.
- **Stuffing across SYNC boundary:** SYNC, bits 1,1,1,1,1 then stuffed 0, then 1,1,1, then 0xFF (stuffed 0 after every run of six 1s counting SYNC's final 1), i_eop → bytes 0xFF,0xFF; o_byte_count=2; no o_err.
- **Stuff error:** SYNC, seven 1s → o_err code 0 after the 7th 1; subsequent bits produce nothing; i_eop gives no o_eop; a following SYNC+0x3C packet is received correctly.
- **Misaligned end:** SYNC, 0x12, 3 extra bits, i_eop → o_byte=0x12 pulse, then o_err code 1 together with o_eop; o_byte_count=1.
- **Overflow and upstream error:** MAX_BYTES=4, 5 bytes → 4 byte pulses, then o_err code 3. Separately, i_error=1 on bit 10 → o_err code 2 and no second byte.
- **Reset mid-packet:** i_rst asserted after 4 data bits → all outputs 0; then SYNC+0x55 → 0x55 with o_sop=1.

Source files
------------

// File: rtl/usb_pkg.sv
// Shared types and constants for the USB receive unstuff/deserialise stage.
package usb_pkg;

  typedef enum logic [1:0] {
    ST_HUNT = 2'd0,
    ST_DATA = 2'd1,
    ST_DROP = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    ERR_STUFF    = 2'd0,
    ERR_ALIGN    = 2'd1,
    ERR_UPSTREAM = 2'd2,
    ERR_OVERFLOW = 2'd3
  } err_code_t;

  // Seven 0s then a 1, newest bit in bit 7.
  localparam logic [7:0] USB_SYNC = 8'h80;

  localparam int DEFAULT_STUFF_RUN = 6;

endpackage

// File: rtl/usb_sync_hunt.sv
// SYNC detector: 8-bit bit history with a comparator against USB_SYNC.
// sync_found is combinational and coincides with the final SYNC bit, so the
// parent FSM enters DATA on that same clock edge.
module usb_sync_hunt
  import usb_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic data,
  input  logic valid,
  input  logic error,
  output logic sync_found
);

  logic [7:0] history;
  logic [7:0] history_next;

  // Candidate history with the incoming bit shifted in at the top.
  always_comb begin
    history_next = {data, history[7:1]};
    sync_found   = enable && valid && !error && (history_next == USB_SYNC);
  end

  // History only accumulates while hunting; it restarts empty after each hunt.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      history <= '0;
    end else if (!enable || sync_found) begin
      history <= '0;
    end else if (valid) begin
      history <= error ? 8'h00 : history_next;
    end
  end

endmodule

// File: rtl/usb_unstuff_deser.sv
// Removes USB bit stuffing after SYNC and assembles LSB-first bytes,
// framing them with start/end markers and one error report per packet.
//
// state | meaning
// HUNT  | searching for SYNC; i_eop ignored
// DATA  | unstuffing and assembling bytes of a packet
// DROP  | packet aborted after an error; waiting for i_eop
module usb_unstuff_deser
  import usb_pkg::*;
#(
  parameter  int STUFF_RUN = DEFAULT_STUFF_RUN,
  parameter  int MAX_BYTES = 64,
  localparam int CNT_W     = $clog2(MAX_BYTES + 1)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_data,
  input  logic             i_valid,
  input  logic             i_error,
  input  logic             i_eop,
  output logic [7:0]       o_byte,
  output logic             o_byte_valid,
  output logic             o_sop,
  output logic             o_eop,
  output logic [CNT_W-1:0] o_byte_count,
  output logic             o_err,
  output logic [1:0]       o_err_code
);

  localparam int ONES_W = $clog2(STUFF_RUN + 1);

  state_t           state, state_next;
  logic [ONES_W-1:0] ones_cnt, ones_next;
  logic [2:0]       bit_cnt, bit_next;
  logic [7:0]       shreg, shreg_next;
  logic [CNT_W-1:0] byte_cnt_next;
  logic             first_byte, first_next;
  logic [7:0]       byte_next;
  logic             byte_valid_next, sop_next, eop_next, err_next;
  logic [1:0]       code_next;
  logic             sync_found;

  usb_sync_hunt u_sync_hunt (
    .clk        (i_clk),
    .rst        (i_rst),
    .enable     (state == ST_HUNT),
    .data       (i_data),
    .valid      (i_valid),
    .error      (i_error),
    .sync_found (sync_found)
  );

  // Next-state and next-output decode; pulses default low, data regs hold.
  always_comb begin
    state_next      = state;
    ones_next       = ones_cnt;
    bit_next        = bit_cnt;
    shreg_next      = shreg;
    byte_cnt_next   = o_byte_count;
    first_next      = first_byte;
    byte_next       = o_byte;
    byte_valid_next = 1'b0;
    sop_next        = 1'b0;
    eop_next        = 1'b0;
    err_next        = 1'b0;
    code_next       = 2'd0;

    case (state)
      ST_HUNT: begin
        if (sync_found) begin
          state_next    = ST_DATA;
          ones_next     = ONES_W'(1);
          bit_next      = '0;
          byte_cnt_next = '0;
          first_next    = 1'b1;
        end
      end

      ST_DATA: begin
        // EOP takes priority over a bit arriving in the same cycle.
        if (i_eop) begin
          eop_next   = 1'b1;
          state_next = ST_HUNT;
          if (bit_cnt != 3'd0) begin
            err_next  = 1'b1;
            code_next = ERR_ALIGN;
          end
        end else if (i_valid) begin
          if (i_error) begin
            err_next   = 1'b1;
            code_next  = ERR_UPSTREAM;
            state_next = ST_DROP;
          end else if (ones_cnt == ONES_W'(STUFF_RUN)) begin
            if (i_data) begin
              err_next   = 1'b1;
              code_next  = ERR_STUFF;
              state_next = ST_DROP;
            end else begin
              ones_next = '0;
            end
          end else begin
            ones_next  = i_data ? ones_cnt + 1'b1 : '0;
            shreg_next = {i_data, shreg[7:1]};
            bit_next   = bit_cnt + 1'b1;
            if (bit_cnt == 3'd7) begin
              if (o_byte_count == CNT_W'(MAX_BYTES)) begin
                err_next   = 1'b1;
                code_next  = ERR_OVERFLOW;
                state_next = ST_DROP;
              end else begin
                byte_valid_next = 1'b1;
                byte_next       = shreg_next;
                sop_next        = first_byte;
                first_next      = 1'b0;
                byte_cnt_next   = o_byte_count + 1'b1;
              end
            end
          end
        end
      end

      ST_DROP: begin
        if (i_eop) state_next = ST_HUNT;
      end

      default: state_next = ST_HUNT;
    endcase
  end

  // State, datapath and registered outputs.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state        <= ST_HUNT;
      ones_cnt     <= '0;
      bit_cnt      <= '0;
      shreg        <= '0;
      first_byte   <= 1'b0;
      o_byte       <= '0;
      o_byte_valid <= 1'b0;
      o_sop        <= 1'b0;
      o_eop        <= 1'b0;
      o_byte_count <= '0;
      o_err        <= 1'b0;
      o_err_code   <= 2'd0;
    end else begin
      state        <= state_next;
      ones_cnt     <= ones_next;
      bit_cnt      <= bit_next;
      shreg        <= shreg_next;
      first_byte   <= first_next;
      o_byte       <= byte_next;
      o_byte_valid <= byte_valid_next;
      o_sop        <= sop_next;
      o_eop        <= eop_next;
      o_byte_count <= byte_cnt_next;
      o_err        <= err_next;
      o_err_code   <= code_next;
    end
  end

endmodule

// File: tb/tb_usb_unstuff_deser.sv
// Bench for usb_unstuff_deser: directed packets plus randomized packets,
// every cycle compared against a bit-queue reference model.
module tb_usb_unstuff_deser;

  localparam int MAXB = 4;
  localparam int RUN  = 6;
  localparam int CW   = $clog2(MAXB + 1);

  localparam int M_HUNT = 0;
  localparam int M_DATA = 1;
  localparam int M_DROP = 2;

  logic          clk = 1'b0;
  logic          rst, data, valid, error, eop;
  logic [7:0]    byte_o;
  logic          byte_valid, sop, eop_o, err;
  logic [CW-1:0] cnt;
  logic [1:0]    code;

  always #5 clk = ~clk;

  usb_unstuff_deser #(.STUFF_RUN(RUN), .MAX_BYTES(MAXB)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_data       (data),
    .i_valid      (valid),
    .i_error      (error),
    .i_eop        (eop),
    .o_byte       (byte_o),
    .o_byte_valid (byte_valid),
    .o_sop        (sop),
    .o_eop        (eop_o),
    .o_byte_count (cnt),
    .o_err        (err),
    .o_err_code   (code)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // reference model state
  int         m_mode;
  logic [7:0] m_hist;
  int         m_run;
  logic       m_bits[$];
  int         m_nbytes;
  bit         m_first;
  logic [7:0] e_byte;
  logic       e_bv, e_sop, e_eop, e_err;
  logic [1:0] e_code;
  int         e_cnt;

  // observation logs for directed checks
  logic [7:0] got_bytes[$];
  int         got_errs[$];
  int         sop_cnt, eop_cnt;

  // stimulus control
  int tx_run;
  int bit_idx;
  int err_at;
  bit no_stuff;
  bit gaps;

  task automatic model_reset();
    m_mode = M_HUNT; m_hist = 8'h00; m_run = 0; m_bits.delete();
    m_nbytes = 0; m_first = 0;
    e_byte = 8'h00; e_bv = 0; e_sop = 0; e_eop = 0; e_err = 0; e_code = 0; e_cnt = 0;
  endtask

  task automatic model_step(input logic v, input logic d, input logic e, input logic p);
    logic [7:0] b;
    e_bv = 0; e_sop = 0; e_eop = 0; e_err = 0; e_code = 0;
    case (m_mode)
      M_HUNT: if (v) begin
        if (e) m_hist = 8'h00;
        else begin
          m_hist = (m_hist >> 1) | (d ? 8'h80 : 8'h00);
          if (m_hist == 8'h80) begin
            m_mode = M_DATA; m_run = 1; m_bits.delete();
            m_nbytes = 0; m_first = 1; e_cnt = 0;
          end
        end
      end
      M_DATA: begin
        if (p) begin
          e_eop = 1;
          if (m_bits.size() != 0) begin e_err = 1; e_code = 2'd1; end
          m_mode = M_HUNT; m_hist = 8'h00;
        end else if (v) begin
          if (e) begin
            e_err = 1; e_code = 2'd2; m_mode = M_DROP;
          end else if (m_run == RUN) begin
            if (d) begin e_err = 1; e_code = 2'd0; m_mode = M_DROP; end
            else m_run = 0;
          end else begin
            m_run = d ? m_run + 1 : 0;
            m_bits.push_back(d);
            if (m_bits.size() == 8) begin
              if (m_nbytes == MAXB) begin
                e_err = 1; e_code = 2'd3; m_mode = M_DROP;
              end else begin
                b = 8'h00;
                for (int i = 0; i < 8; i++) b[i] = m_bits[i];
                e_byte = b; e_bv = 1; e_sop = m_first; m_first = 0;
                m_nbytes++; e_cnt = m_nbytes;
              end
              m_bits.delete();
            end
          end
        end
      end
      M_DROP: if (p) begin m_mode = M_HUNT; m_hist = 8'h00; end
      default: m_mode = M_HUNT;
    endcase
  endtask

  task automatic compare_all();
    check("byte_valid", byte_valid, e_bv);
    check("byte", byte_o, e_byte);
    check("sop", sop, e_sop);
    check("eop", eop_o, e_eop);
    check("err", err, e_err);
    check("err_code", code, e_code);
    check("byte_count", cnt, e_cnt);
  endtask

  task automatic cycle(input logic v, input logic d, input logic e, input logic p);
    valid = v; data = d; error = e; eop = p;
    @(posedge clk);
    #1;
    model_step(v, d, e, p);
    compare_all();
    if (byte_valid) got_bytes.push_back(byte_o);
    if (sop) sop_cnt++;
    if (eop_o) eop_cnt++;
    if (err) got_errs.push_back(int'(code));
  endtask

  task automatic clear_logs();
    got_bytes.delete(); got_errs.delete(); sop_cnt = 0; eop_cnt = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0);
  endtask

  task automatic send_bit(input logic b);
    if (gaps && ($urandom % 4 == 0)) cycle(0, 0, 0, 0);
    cycle(1, b, (bit_idx == err_at), 0);
    bit_idx++;
    tx_run = b ? tx_run + 1 : 0;
  endtask

  task automatic send_sync();
    for (int i = 0; i < 7; i++) cycle(1, 0, 0, 0);
    cycle(1, 1, 0, 0);
    tx_run = 1; bit_idx = 0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 0; i < 8; i++) begin
      if (tx_run == RUN && !no_stuff) send_bit(1'b0);
      send_bit(b[i]);
    end
  endtask

  task automatic send_eop();
    cycle(0, 0, 0, 1);
  endtask

  function automatic logic [31:0] byte_at(input int i);
    return (i < got_bytes.size()) ? 32'(got_bytes[i]) : 32'hDEAD;
  endfunction

  function automatic logic [31:0] err_at_idx(input int i);
    return (i < got_errs.size()) ? 32'(got_errs[i]) : 32'hDEAD;
  endfunction

  initial begin
    int nb;
    int extra;
    rst = 1; data = 0; valid = 0; error = 0; eop = 0;
    err_at = -1; no_stuff = 0; gaps = 0; tx_run = 0; bit_idx = 0;
    model_reset();
    clear_logs();
    repeat (2) @(posedge clk);
    #1;
    compare_all();
    @(negedge clk);
    rst = 0;
    idle(2);

    // clean packet
    clear_logs();
    send_sync(); send_byte(8'hA5); send_eop(); idle(2);
    check("clean_nbytes", got_bytes.size(), 1);
    check("clean_byte", byte_at(0), 8'hA5);
    check("clean_sop", sop_cnt, 1);
    check("clean_eop", eop_cnt, 1);
    check("clean_errs", got_errs.size(), 0);
    check("clean_count", cnt, 1);

    // stuffing across SYNC boundary
    clear_logs();
    send_sync(); send_byte(8'hFF); send_byte(8'hFF); send_eop(); idle(2);
    check("stuff_nbytes", got_bytes.size(), 2);
    check("stuff_byte0", byte_at(0), 8'hFF);
    check("stuff_byte1", byte_at(1), 8'hFF);
    check("stuff_errs", got_errs.size(), 0);
    check("stuff_count", cnt, 2);

    // stuff error, then a good packet
    clear_logs();
    send_sync();
    for (int i = 0; i < 7; i++) send_bit(1'b1);
    for (int i = 0; i < 10; i++) send_bit(1'($urandom));
    send_eop(); idle(2);
    check("stufferr_errs", got_errs.size(), 1);
    check("stufferr_code", err_at_idx(0), 0);
    check("stufferr_eop", eop_cnt, 0);
    check("stufferr_bytes", got_bytes.size(), 0);
    clear_logs();
    send_sync(); send_byte(8'h3C); send_eop(); idle(2);
    check("after_err_byte", byte_at(0), 8'h3C);
    check("after_err_eop", eop_cnt, 1);

    // misaligned end
    clear_logs();
    send_sync(); send_byte(8'h12); send_bit(1); send_bit(0); send_bit(1);
    send_eop(); idle(2);
    check("align_byte", byte_at(0), 8'h12);
    check("align_code", err_at_idx(0), 1);
    check("align_eop", eop_cnt, 1);
    check("align_count", cnt, 1);

    // overflow
    clear_logs();
    send_sync();
    for (int i = 1; i <= 5; i++) send_byte(8'(i));
    send_eop(); idle(2);
    check("ovf_nbytes", got_bytes.size(), 4);
    check("ovf_code", err_at_idx(0), 3);
    check("ovf_eop", eop_cnt, 0);
    check("ovf_count", cnt, 4);

    // upstream error on bit 10 (index 9)
    clear_logs();
    err_at = 9;
    send_sync(); send_byte(8'h11); send_byte(8'h22);
    err_at = -1;
    send_eop(); idle(2);
    check("ups_nbytes", got_bytes.size(), 1);
    check("ups_code", err_at_idx(0), 2);
    check("ups_nerr", got_errs.size(), 1);

    // reset mid-packet
    send_sync();
    for (int i = 0; i < 4; i++) send_bit(1'(i & 1));
    rst = 1;
    #1;
    model_reset();
    compare_all();
    valid = 0; eop = 0; error = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 0;
    idle(2);
    clear_logs();
    send_sync(); send_byte(8'h55); send_eop(); idle(2);
    check("rst_byte", byte_at(0), 8'h55);
    check("rst_sop", sop_cnt, 1);

    // randomized packets
    for (int pkt = 0; pkt < 150; pkt++) begin
      gaps     = ($urandom % 3 == 0);
      no_stuff = ($urandom % 8 == 0);
      err_at   = ($urandom % 8 == 0) ? int'($urandom_range(0, 40)) : -1;
      for (int i = 0; i < int'($urandom_range(0, 3)); i++) cycle(0, 0, ($urandom % 2 == 0), 0);
      if ($urandom % 6 == 0)
        for (int i = 0; i < int'($urandom_range(1, 5)); i++) cycle(1, 1'($urandom), 0, 0);
      send_sync();
      nb = $urandom_range(0, 5);
      for (int i = 0; i < nb; i++)
        send_byte(($urandom % 3 == 0) ? 8'hFF : 8'($urandom));
      extra = ($urandom % 3 == 0) ? int'($urandom_range(1, 7)) : 0;
      for (int i = 0; i < extra; i++) send_bit(1'($urandom));
      if ($urandom % 4 == 0) cycle(1, 1'($urandom), 0, 1);
      else send_eop();
      idle($urandom_range(0, 2));
    end
    gaps = 0; no_stuff = 0; err_at = -1;
    idle(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
